// File: rtl/lag_pl_sep_allocator.sv
// rtl/lag_pl_sep_allocator.sv - separable round-robin packet-lane allocator with free/busy tracking
module lag_pl_sep_allocator #(
    parameter int np           = 5,
    parameter int nv           = 4,
    parameter int alloc_stages = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [np*nv-1:0]    req,
    input  logic [np*nv*np-1:0] req_port,
    input  logic [np*nv*nv-1:0] req_mask,
    input  logic [np*nv-1:0]    pl_release,
    output logic [np*nv*nv-1:0] pl_new,
    output logic [np*nv-1:0]    pl_new_valid,
    output logic [np*nv-1:0]    pl_allocated,
    output logic [np*nv-1:0]    pl_free,
    output logic                release_err
);
    localparam int ni  = np * nv;
    localparam int vw  = (nv > 1) ? $clog2(nv) : 1;
    localparam int pw  = (np > 1) ? $clog2(np) : 1;
    localparam int iw  = (ni > 1) ? $clog2(ni) : 1;
    localparam bit two = (alloc_stages == 2);

    if (alloc_stages != 1 && alloc_stages != 2) begin : g_bad_stages
        $error("lag_pl_sep_allocator: alloc_stages must be 1 or 2");
    end

    function automatic logic [vw-1:0] rot_v(input logic [vw-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= nv) s = s - nv;
        return vw'(s);
    endfunction

    function automatic logic [iw-1:0] rot_i(input logic [iw-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= ni) s = s - ni;
        return iw'(s);
    endfunction

    function automatic logic [iw-1:0] pl_idx(input logic [pw-1:0] p, input logic [vw-1:0] w);
        return iw'(int'(p) * nv + int'(w));
    endfunction

    logic [vw-1:0] rr1 [ni];
    logic [iw-1:0] rr2 [ni];
    logic [ni-1:0] nom_valid;
    logic [pw-1:0] nom_port [ni];
    logic [vw-1:0] nom_w [ni];

    logic [ni-1:0] elig, s1_valid, s2_valid, alloc, gnt;
    logic [pw-1:0] s1_port [ni], s2_port [ni];
    logic [vw-1:0] s1_w [ni], s2_w [ni], gnt_w [ni];
    logic [nv-1:0] cand [ni];
    logic [iw-1:0] win [ni];

    // An input with a nomination in flight must not nominate again until it resolves.
    assign elig = req & ~pl_new_valid & ~nom_valid;

    always_comb begin
        for (int i = 0; i < ni; i++) begin
            s1_port[i]  = '0;
            s1_valid[i] = 1'b0;
            s1_w[i]     = '0;
            cand[i]     = '0;
            for (int o = 0; o < np; o++) begin
                if (req_port[i*np + o]) begin
                    s1_port[i] = pw'(o);
                    cand[i]    = cand[i] | pl_free[o*nv +: nv];
                end
            end
            cand[i] = elig[i] ? (cand[i] & req_mask[i*nv +: nv]) : '0;
            for (int k = 0; k < nv; k++) begin
                if (!s1_valid[i] && cand[i][rot_v(rr1[i], k)]) begin
                    s1_valid[i] = 1'b1;
                    s1_w[i]     = rot_v(rr1[i], k);
                end
            end
        end
    end

    // Registered nominations are re-qualified against the current free map and req.
    always_comb begin
        for (int i = 0; i < ni; i++) begin
            if (two) begin
                s2_valid[i] = nom_valid[i] & req[i] & pl_free[pl_idx(nom_port[i], nom_w[i])];
                s2_port[i]  = nom_port[i];
                s2_w[i]     = nom_w[i];
            end else begin
                s2_valid[i] = s1_valid[i];
                s2_port[i]  = s1_port[i];
                s2_w[i]     = s1_w[i];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < ni; k++) begin
            alloc[k] = 1'b0;
            win[k]   = '0;
            for (int j = 0; j < ni; j++) begin
                if (!alloc[k] && s2_valid[rot_i(rr2[k], j)] &&
                    pl_idx(s2_port[rot_i(rr2[k], j)], s2_w[rot_i(rr2[k], j)]) == iw'(k)) begin
                    alloc[k] = 1'b1;
                    win[k]   = rot_i(rr2[k], j);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < ni; i++) gnt_w[i] = '0;
        for (int k = 0; k < ni; k++) begin
            if (alloc[k]) begin
                gnt[win[k]]   = 1'b1;
                gnt_w[win[k]] = vw'(k % nv);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_free      <= '1;
            pl_new       <= '0;
            pl_new_valid <= '0;
            pl_allocated <= '0;
            release_err  <= 1'b0;
            nom_valid    <= '0;
            for (int i = 0; i < ni; i++) begin
                rr1[i]      <= '0;
                rr2[i]      <= '0;
                nom_port[i] <= '0;
                nom_w[i]    <= '0;
            end
        end else begin
            pl_free      <= (pl_free & ~alloc) | (pl_release & ~pl_free);
            pl_allocated <= alloc;
            pl_new_valid <= gnt;
            release_err  <= |(pl_release & pl_free);
            nom_valid    <= two ? s1_valid : '0;
            for (int i = 0; i < ni; i++) begin
                nom_port[i]         <= s1_port[i];
                nom_w[i]            <= s1_w[i];
                pl_new[i*nv +: nv]  <= gnt[i] ? (nv'(1) << gnt_w[i]) : '0;
                if (gnt[i]) rr1[i]  <= (gnt_w[i] == vw'(nv - 1)) ? '0 : gnt_w[i] + vw'(1);
                if (alloc[i]) rr2[i] <= (win[i] == iw'(ni - 1)) ? '0 : win[i] + iw'(1);
            end
        end
    end
endmodule

// File: tb/tb_lag_pl_sep_allocator.sv
// tb/tb_lag_pl_sep_allocator.sv - directed and randomized bench for lag_pl_sep_allocator
module tb_lag_pl_sep_allocator;
    localparam int np = 5;
    localparam int nv = 4;
    localparam int ni = np * nv;

    logic clk = 1'b0;
    logic rst_n, rst2_n;
    logic [ni-1:0]    req, pl_release, req2, pl_release2;
    logic [ni*np-1:0] req_port, req_port2;
    logic [ni*nv-1:0] req_mask, req_mask2;
    logic [ni*nv-1:0] pl_new, pl_new2;
    logic [ni-1:0]    pl_new_valid, pl_allocated, pl_free;
    logic [ni-1:0]    pl_new_valid2, pl_allocated2, pl_free2;
    logic             release_err, release_err2;

    always #5 clk = ~clk;

    lag_pl_sep_allocator #(.np(np), .nv(nv), .alloc_stages(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_port(req_port), .req_mask(req_mask),
        .pl_release(pl_release), .pl_new(pl_new), .pl_new_valid(pl_new_valid),
        .pl_allocated(pl_allocated), .pl_free(pl_free), .release_err(release_err)
    );

    lag_pl_sep_allocator #(.np(np), .nv(nv), .alloc_stages(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req(req2), .req_port(req_port2), .req_mask(req_mask2),
        .pl_release(pl_release2), .pl_new(pl_new2), .pl_new_valid(pl_new_valid2),
        .pl_allocated(pl_allocated2), .pl_free(pl_free2), .release_err(release_err2)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference state for the single-stage instance, described per output PL and per input PL.
    bit [ni-1:0] m_free, m_valid, m_alloc;
    bit          m_err;
    int          m_rr1 [ni];
    int          m_rr2 [ni];
    int          m_w [ni];
    bit          chk_en = 1'b0;
    bit [ni-1:0] linger;
    logic [ni*nv-1:0] e_new;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_free = '1; m_valid = '0; m_alloc = '0; m_err = 1'b0;
        for (int i = 0; i < ni; i++) begin
            m_rr1[i] = 0; m_rr2[i] = 0; m_w[i] = 0;
        end
    endtask

    task automatic step();
        int nom_o [ni];
        int nom_w [ni];
        int win [ni];
        int n_w [ni];
        int w;
        int cand_i;
        bit [ni-1:0] n_valid, n_alloc, n_free;
        bit n_err;
        for (int a = 0; a < ni; a++) begin
            nom_o[a] = -1; nom_w[a] = -1; n_w[a] = 0;
            if (req[a] && !m_valid[a]) begin
                for (int o = 0; o < np; o++) if (req_port[a*np + o]) nom_o[a] = o;
                if (nom_o[a] >= 0) begin
                    for (int k = 0; k < nv; k++) begin
                        w = (m_rr1[a] + k) % nv;
                        if (nom_w[a] < 0 && req_mask[a*nv + w] && m_free[nom_o[a]*nv + w]) nom_w[a] = w;
                    end
                end
            end
        end
        n_valid = '0; n_alloc = '0;
        for (int pl = 0; pl < ni; pl++) begin
            win[pl] = -1;
            for (int j = 0; j < ni; j++) begin
                cand_i = (m_rr2[pl] + j) % ni;
                if (win[pl] < 0 && nom_w[cand_i] >= 0 && nom_o[cand_i]*nv + nom_w[cand_i] == pl) win[pl] = cand_i;
            end
            if (win[pl] >= 0) begin
                n_alloc[pl] = 1'b1;
                n_valid[win[pl]] = 1'b1;
                n_w[win[pl]] = pl % nv;
            end
        end
        n_free = (m_free & ~n_alloc) | (pl_release & ~m_free);
        n_err  = |(pl_release & m_free);
        @(posedge clk);
        #1;
        for (int pl = 0; pl < ni; pl++) begin
            if (win[pl] >= 0) begin
                m_rr2[pl] = (win[pl] + 1) % ni;
                m_rr1[win[pl]] = (pl % nv + 1) % nv;
            end
        end
        for (int i = 0; i < ni; i++) m_w[i] = n_w[i];
        m_valid = n_valid; m_alloc = n_alloc; m_free = n_free; m_err = n_err;
    endtask

    task automatic set_req(input int i, input int port, input logic [nv-1:0] mask);
        req_port[i*np +: np] = '0;
        req_port[i*np + port] = 1'b1;
        req_mask[i*nv +: nv] = mask;
        req[i] = 1'b1;
    endtask

    task automatic set_req2(input int i, input int port, input logic [nv-1:0] mask);
        req_port2[i*np +: np] = '0;
        req_port2[i*np + port] = 1'b1;
        req_mask2[i*nv +: nv] = mask;
        req2[i] = 1'b1;
    endtask

    task automatic cleanup();
        req = '0;
        pl_release = ~m_free;
        step();
        pl_release = '0;
        step();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_new = '0;
            for (int i = 0; i < ni; i++) if (m_valid[i]) e_new[i*nv + m_w[i]] = 1'b1;
            check("model pl_new_valid", pl_new_valid, m_valid);
            check("model pl_new", pl_new, e_new);
            check("model pl_allocated", pl_allocated, m_alloc);
            check("model pl_free", pl_free, m_free);
            check("model release_err", release_err, m_err);
        end
    end

    initial begin
        int tgt;
        req = '0; req_port = '0; req_mask = '0; pl_release = '0;
        req2 = '0; req_port2 = '0; req_mask2 = '0; pl_release2 = '0;
        linger = '0;
        rst_n = 1'b0; rst2_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset free", pl_free, 20'hFFFFF);
        check("reset valid", pl_new_valid, 20'h0);
        check("reset new", pl_new, 80'h0);
        check("reset alloc", pl_allocated, 20'h0);
        check("reset err", release_err, 1'b0);
        check("reset2 free", pl_free2, 20'hFFFFF);
        model_reset();
        rst_n = 1'b1; rst2_n = 1'b1;
        chk_en = 1'b1;

        // single request, port 2
        set_req(0, 2, 4'hF);
        step();
        check("single valid", pl_new_valid, 20'h00001);
        check("single new", pl_new[3:0], 4'b0001);
        check("single alloc", pl_allocated, 20'h00100);
        check("single free p2", pl_free[11:8], 4'b1110);
        cleanup();

        // conflict on (4,2)
        set_req(0, 4, 4'b0100); set_req(4, 4, 4'b0100); set_req(14, 4, 4'b0100);
        step();
        check("conflict first", pl_new_valid, 20'h00001);
        req[0] = 1'b0; pl_release[18] = 1'b1;
        step();
        check("conflict release cycle", pl_new_valid, 20'h0);
        pl_release[18] = 1'b0;
        step();
        check("conflict second", pl_new_valid, 20'h00010);
        req[4] = 1'b0; pl_release[18] = 1'b1;
        step();
        pl_release[18] = 1'b0;
        step();
        check("conflict third", pl_new_valid, 20'h04000);
        req[14] = 1'b0; req[0] = 1'b1; req[4] = 1'b1; pl_release[18] = 1'b1;
        step();
        pl_release[18] = 1'b0;
        step();
        check("conflict wrap", pl_new_valid, 20'h00001);
        cleanup();

        // exhaust port 1, then free (1,3)
        for (int n = 0; n < 4; n++) begin
            set_req(10, 1, 4'hF);
            step();
            req[10] = 1'b0;
            step();
        end
        check("exhaust free p1", pl_free[7:4], 4'b0000);
        set_req(10, 1, 4'hF);
        step();
        step();
        check("exhaust no grant", pl_new_valid, 20'h0);
        pl_release[7] = 1'b1;
        step();
        check("exhaust release cycle", pl_new_valid, 20'h0);
        pl_release[7] = 1'b0;
        step();
        check("exhaust grant", pl_new_valid, 20'h00400);
        check("exhaust new w3", pl_new[43:40], 4'b1000);
        cleanup();

        // release of a free PL
        pl_release[9] = 1'b1;
        step();
        check("relerr pulse", release_err, 1'b1);
        check("relerr free", pl_free, 20'hFFFFF);
        pl_release[9] = 1'b0;
        step();
        check("relerr clear", release_err, 1'b0);

        // parallel grants to five distinct ports
        for (int p = 0; p < np; p++) set_req(p*nv, (p + 1) % np, 4'hF);
        step();
        check("parallel valid", pl_new_valid, 20'h11111);
        check("parallel count", $countones(pl_allocated), 5);
        cleanup();

        // two-stage instance
        set_req2(0, 2, 4'hF);
        step();
        check("s2 edge1 valid", pl_new_valid2, 20'h0);
        step();
        check("s2 latency valid", pl_new_valid2, 20'h00001);
        check("s2 latency new", pl_new2[3:0], 4'b0001);
        check("s2 latency alloc", pl_allocated2, 20'h00100);
        check("s2 latency free", pl_free2[11:8], 4'b1110);
        req2[0] = 1'b0;
        set_req2(5, 3, 4'b0001);
        step();
        req2[5] = 1'b0;
        step();
        check("s2 cancel valid", pl_new_valid2, 20'h0);
        check("s2 cancel alloc", pl_allocated2, 20'h0);
        step();
        check("s2 cancel free", pl_free2, 20'hFFEFF);

        set_req2(1, 3, 4'b0001);
        step();
        set_req2(2, 3, 4'b0001);
        step();
        check("s2 busy first", pl_new_valid2, 20'h00002);
        req2[1] = 1'b0;
        step();
        check("s2 busy dropped", pl_new_valid2, 20'h0);
        pl_release2[12] = 1'b1;
        step();
        check("s2 busy retry", pl_new_valid2, 20'h0);
        check("s2 busy released", pl_free2[12], 1'b1);
        pl_release2[12] = 1'b0;
        step();
        check("s2 busy nominate", pl_new_valid2, 20'h0);
        step();
        check("s2 busy grant", pl_new_valid2, 20'h00004);
        check("s2 busy new", pl_new2[11:8], 4'b0001);
        req2[2] = 1'b0;

        set_req2(7, 0, 4'hF);
        step();
        rst2_n = 1'b0;
        #1;
        check("s2 async free", pl_free2, 20'hFFFFF);
        check("s2 async valid", pl_new_valid2, 20'h0);
        check("s2 async alloc", pl_allocated2, 20'h0);
        check("s2 async new", pl_new2, 80'h0);
        step();
        rst2_n = 1'b1;
        step();
        check("s2 post-reset no grant", pl_new_valid2, 20'h0);
        step();
        check("s2 post-reset fresh grant", pl_new_valid2, 20'h00080);
        req2[7] = 1'b0;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < ni; i++) begin
                if (linger[i]) begin
                    req[i] = 1'b0; linger[i] = 1'b0;
                end else if (m_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) linger[i] = 1'b1;
                    else req[i] = 1'b0;
                end else if (req[i]) begin
                    if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    tgt = $urandom_range(0, np - 1);
                    set_req(i, tgt, nv'($urandom_range(0, 15)));
                end
            end
            for (int k = 0; k < ni; k++)
                pl_release[k] = m_free[k] ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 4) == 0);
            step();
        end
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/lag_pl_sep_allocator.md
Name: lag_pl_sep_allocator

Overview:
- Parametrised separable packet-lane (PL) allocator; successor to the single-cycle unrestricted PL allocator in the router.
- Adds three things:
  - internal tracking of free/busy output PLs, with release input;
  - per-request allowed-PL masks;
  - fair round-robin in both stages, selectable 1- or 2-stage pipeline.
- Sits between the input-PL header decode and the output-PL credit and switch allocators.

Parameters:
- np, 5, number of router ports (inputs = outputs).
- nv, 4, PLs per port.
- alloc_stages, 1, pipeline depth. 1 = both arbitration stages in one cycle. 2 = stage-1 result registered. Any other value is illegal (elaboration error).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req, in, np*nv, input PL (p,v) requests an output PL. Held until granted.
- req_port, in, np*nv*np, one-hot target output port per input PL. Valid while req is high.
- req_mask, in, np*nv*nv, output-PL indices (p,v) may accept. An all-zero mask is never granted.
- pl_release, in, np*nv, output PL (o,w) freed (tail flit departed). One-cycle pulse.
- pl_new, out, np*nv*nv, one-hot index of the output PL granted to (p,v).
- pl_new_valid, out, np*nv, grant pulse for (p,v).
- pl_allocated, out, np*nv, output PL (o,w) allocated on this edge.
- pl_free, out, np*nv, free-status register.
- release_err, out, 1, release of an already-free PL. Registered pulse.

Behaviour:
- Reset (async, rst_n=0):
  - pl_free all 1; pl_new, pl_new_valid, pl_allocated, release_err all 0.
  - All round-robin pointers point to index 0.
  - Stage-1 pipeline register invalid.
- Eligibility: (p,v) is eligible when all of the following hold:
  - req=1;
  - pl_new_valid[p][v]=0 (requester drops req the cycle after seeing valid);
  - no nomination pending in the stage-1 register (alloc_stages=2 only).
- Stage 1 (per input PL, nv:1 round-robin):
  - Candidate set = req_mask & pl_free[target port]. No candidate means no nomination.
  - Pointer rr1[p][v] advances to (winner+1) mod nv only when the final grant is registered.
- Stage 2 (per output PL (o,w), np*nv:1 round-robin):
  - Arbitrates among all nominations for (o,w).
  - Pointer rr2[o][w] advances to (winner+1) mod np*nv on grant.
- Losing stage 2 produces no output; the input retries in the next cycle and keeps its stage-1 pointer.
- Grant registration, at the edge ending the stage-2 cycle:
  - pl_new_valid[p][v]=1 and pl_new[p][v]=one-hot w;
  - pl_allocated[o][w]=1 and pl_free[o][w] cleared.
  - All three outputs are single-cycle pulses, then return to 0.
- At most one grant per output PL per cycle. An input PL gets at most one grant.
- Latency, req rising to pl_new_valid: 1 cycle (alloc_stages=1); 2 cycles (alloc_stages=2), when uncontended.
- alloc_stages=2 nominations:
  - Stage 2 re-checks pl_free using the registered value at the second cycle.
  - A nomination whose target became busy is dropped silently; the input re-enters stage 1 next cycle.
- Release:
  - pl_release[o][w]=1 with pl_free[o][w]=0 sets pl_free at the next edge. The PL is allocatable from that cycle on.
  - A release on a PL that is already free is ignored and pulses release_err next cycle.
- Simultaneous events:
  - Release and allocation on the same PL in one cycle cannot occur legally: allocation needs free, release needs busy.
  - If release is presented on a free PL that is granted on that edge, the grant wins and release_err pulses.
- req dropped mid-pipeline (alloc_stages=2): the pending nomination is cancelled before stage 2. No grant, no pointer update.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset then single request: req[0][0]=1, req_port=port 2, mask=4'b1111 → pl_new_valid[0][0] after 1 cycle (2 for alloc_stages=2), pl_new=4'b0001, pl_allocated[2][0]=1, pl_free[2]=4'b1110.
- Conflict: inputs (0,0), (1,0), (3,2) request port 4, mask=4'b0100 → three successive grants of (4,2) only after each pl_release[4][2]. Grant order (0,0), (1,0), (3,2); then the rr2 pointer wraps so (0,0) wins next.
- Mask/exhaustion: port 1 all busy, request with mask=4'b1111 → no grant. pl_release[1][3] → grant w=3 next cycle (1-stage).
- Release on free PL: pl_release[2][1] with pl_free[2][1]=1 → release_err one-cycle pulse, pl_free unchanged.
- Parallel grants: 5 inputs target 5 distinct ports in the same cycle → 5 pl_new_valid bits in the same cycle.
- Async reset mid-operation (alloc_stages=2, nomination pending): rst_n low → all outputs 0 immediately, pl_free all 1, no grant after reset release.
